// File: rtl/acc_fold_chain_pkg.sv
// -----------------------------------------------------------------------------
// acc_fold_chain_pkg
//   Shared definitions for the acc_fold_chain accumulator chain:
//   - MAX_W        : widest stage-2 datapath the saturating helper supports
//   - acc1_w()     : width of the stage-1 running sum for a given sample width
//   - acc_mode_e   : stage-2 arithmetic mode (wrap / saturate)
//   - sat_add()    : unsigned saturating add, returns {overflow, result}
// -----------------------------------------------------------------------------
package acc_fold_chain_pkg;

   localparam int unsigned MAX_W = 32;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } acc_mode_e;

   // Stage-1 sum is twice the sample width so the fold sees a full high half.
   function automatic int unsigned acc1_w(input int unsigned data_w);
      return 2 * data_w;
   endfunction

   // Operands are zero-extended into MAX_W bits; w selects the real width.
   // The limit is 2^w - 1, so any sum above it overflows and clamps to it.
   function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] a,
                                              input logic [MAX_W-1:0] b,
                                              input int unsigned      w);
      logic [MAX_W:0] one;
      logic [MAX_W:0] sum;
      logic [MAX_W:0] lim;
      one = {{MAX_W{1'b0}}, 1'b1};
      sum = {1'b0, a} + {1'b0, b};
      lim = (one << w) - one;
      if (sum > lim) begin
         return {1'b1, lim[MAX_W-1:0]};
      end
      return {1'b0, sum[MAX_W-1:0]};
   endfunction

endpackage

// File: rtl/acc_fold_chain_fold.sv
// -----------------------------------------------------------------------------
// fold_add
//   Purely combinational fold of a double-width running sum: adds the low
//   and high halves and drops the carry. Kept as its own module so gate-level
//   variants can be swapped in and checked for equivalence at this boundary.
//
//   Ports:
//     lo  [DATA_W-1:0]  low half of the running sum
//     hi  [DATA_W-1:0]  high half of the running sum
//     sum [DATA_W-1:0]  (lo + hi) mod 2^DATA_W
// -----------------------------------------------------------------------------
module fold_add #(
   parameter int unsigned DATA_W = 8
) (
   input  logic [DATA_W-1:0] lo,
   input  logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] sum
);

   assign sum = lo + hi;

endmodule

// File: rtl/acc_fold_chain.sv
// -----------------------------------------------------------------------------
// acc_fold_chain
//   Multi-channel two-stage accumulator chain.
//   Stage 1 keeps a 2*DATA_W running sum per channel; a fold adder combines
//   its halves; stage 2 accumulates the folded value with wrap or unsigned
//   saturate arithmetic. PIPE=1 inserts a register between fold and stage 2.
//   DATA_W must not exceed acc_fold_chain_pkg::MAX_W.
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous reset, active high
//     in_valid   qualifies in_data for all channels
//     in_data    NCH*DATA_W, channel c at [c*DATA_W +: DATA_W], unsigned
//     clear      synchronous clear of all accumulation state
//     out_valid  one-cycle pulse when out_data carries a new update
//     out_data   NCH*DATA_W stage-2 accumulators, same packing as in_data
//     sat_flag   NCH sticky per-channel saturation flags (0 when SAT=0)
// -----------------------------------------------------------------------------
module acc_fold_chain
   import acc_fold_chain_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NCH    = 1,
   parameter int unsigned PIPE   = 0,
   parameter int unsigned SAT    = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [NCH*DATA_W-1:0] in_data,
   input  logic                  clear,
   output logic                  out_valid,
   output logic [NCH*DATA_W-1:0] out_data,
   output logic [NCH-1:0]        sat_flag
);

   localparam int unsigned ACC1_W = acc1_w(DATA_W);
   localparam acc_mode_e   MODE   = (SAT != 0) ? MODE_SAT : MODE_WRAP;

   // ---------------------------------------------------------------- stage 1
   logic [NCH-1:0][ACC1_W-1:0] acc1_q, acc1_d;
   logic                       v1_q;

   always_comb begin
      acc1_d = acc1_q;
      for (int unsigned c = 0; c < NCH; c++) begin
         // A sample presented together with clear seeds the new run.
         if (clear) begin
            acc1_d[c] = in_valid ? {{DATA_W{1'b0}}, in_data[c*DATA_W +: DATA_W]} : '0;
         end else if (in_valid) begin
            acc1_d[c] = acc1_q[c] + {{DATA_W{1'b0}}, in_data[c*DATA_W +: DATA_W]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc1_q <= '0;
         v1_q   <= 1'b0;
      end else begin
         acc1_q <= acc1_d;
         v1_q   <= in_valid;
      end
   end

   // ------------------------------------------------------------------- fold
   logic [NCH-1:0][DATA_W-1:0] fold;

   for (genvar c = 0; c < int'(NCH); c++) begin : g_ch
      fold_add #(
         .DATA_W (DATA_W)
      ) u_fold (
         .lo  (acc1_q[c][DATA_W-1:0]),
         .hi  (acc1_q[c][ACC1_W-1:DATA_W]),
         .sum (fold[c])
      );
   end

   // --------------------------------------------------- optional fold register
   logic [NCH-1:0][DATA_W-1:0] s2_f;
   logic                       s2_v;

   if (PIPE != 0) begin : g_pipe
      logic [NCH-1:0][DATA_W-1:0] fold_q;
      logic                       v2_q;

      // Clearing here drops the token that was between stages at the clear.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            fold_q <= '0;
            v2_q   <= 1'b0;
         end else if (clear) begin
            fold_q <= '0;
            v2_q   <= 1'b0;
         end else begin
            fold_q <= fold;
            v2_q   <= v1_q;
         end
      end

      assign s2_f = fold_q;
      assign s2_v = v2_q;
   end else begin : g_nopipe
      assign s2_f = fold;
      assign s2_v = v1_q;
   end

   // ---------------------------------------------------------------- stage 2
   logic [NCH-1:0][DATA_W-1:0] acc2_q, acc2_d;
   logic [NCH-1:0]             sat_q, sat_d;
   logic                       ov_q, ov_d;
   logic [NCH-1:0][MAX_W:0]    sat_res;
   logic                       sat_res_unused;

   always_comb begin
      acc2_d  = acc2_q;
      sat_d   = sat_q;
      ov_d    = s2_v;
      sat_res = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         sat_res[c] = sat_add(MAX_W'(acc2_q[c]), MAX_W'(s2_f[c]), DATA_W);
      end
      // clear wins over a token arriving at stage 2 in the same cycle.
      if (clear) begin
         acc2_d = '0;
         sat_d  = '0;
         ov_d   = 1'b0;
      end else if (s2_v) begin
         for (int unsigned c = 0; c < NCH; c++) begin
            if (MODE == MODE_SAT) begin
               acc2_d[c] = sat_res[c][DATA_W-1:0];
               sat_d[c]  = sat_q[c] | sat_res[c][MAX_W];
            end else begin
               acc2_d[c] = acc2_q[c] + s2_f[c];
            end
         end
      end
   end

   // Upper helper bits beyond DATA_W are always zero and are not needed.
   assign sat_res_unused = ^sat_res;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc2_q <= '0;
         sat_q  <= '0;
         ov_q   <= 1'b0;
      end else begin
         acc2_q <= acc2_d;
         sat_q  <= sat_d;
         ov_q   <= ov_d;
      end
   end

   assign out_valid = ov_q;
   assign out_data  = acc2_q;
   assign sat_flag  = sat_q;

endmodule

// File: tb/tb_acc_fold_chain.sv
// -----------------------------------------------------------------------------
// tb_acc_fold_chain
//   Three instances: u0 (NCH=1, PIPE=0, wrap), u1 (NCH=1, PIPE=0, saturate)
//   sharing one stimulus, and u2 (NCH=2, PIPE=1, wrap) with its own stimulus.
//   Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_acc_fold_chain;

   logic        clk = 1'b0;
   logic        rst;

   logic        clr_a, vld_a;
   logic [7:0]  d_a;
   logic        ov0, ov1;
   logic [7:0]  q0, q1;
   logic        sf0, sf1;

   logic        clr_b, vld_b;
   logic [15:0] d_b, q2;
   logic        ov2;
   logic [1:0]  sf2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   acc_fold_chain #(.DATA_W(8), .NCH(1), .PIPE(0), .SAT(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(vld_a), .in_data(d_a), .clear(clr_a),
      .out_valid(ov0), .out_data(q0), .sat_flag(sf0));

   acc_fold_chain #(.DATA_W(8), .NCH(1), .PIPE(0), .SAT(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(vld_a), .in_data(d_a), .clear(clr_a),
      .out_valid(ov1), .out_data(q1), .sat_flag(sf1));

   acc_fold_chain #(.DATA_W(8), .NCH(2), .PIPE(1), .SAT(0)) u2 (
      .clk(clk), .rst(rst), .in_valid(vld_b), .in_data(d_b), .clear(clr_b),
      .out_valid(ov2), .out_data(q2), .sat_flag(sf2));

   typedef struct packed {
      logic       clr;
      logic       vld;
      logic [7:0] d;
      logic       ov;
      logic [7:0] w;   // u0 out_data
      logic [7:0] s;   // u1 out_data
      logic       sf;  // u1 sat_flag
   } vec_a_t;

   typedef struct packed {
      logic        clr;
      logic        vld;
      logic [15:0] d;
      logic        ov;
      logic [15:0] q;
   } vec_b_t;

   vec_a_t va [21];
   vec_b_t vb [12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
      end
   endtask

   task automatic send_a(input logic c, input logic v, input logic [7:0] d);
      clr_a = c; vld_a = v; d_a = d;
      step();
   endtask

   task automatic send_b(input logic c, input logic v, input logic [15:0] d);
      clr_b = c; vld_b = v; d_b = d;
      step();
   endtask

   task automatic chk_a(input string nm, input int idx, input logic ov, input logic [7:0] w,
                        input logic [7:0] s, input logic sf);
      chk({nm, ".ov0"}, idx, 32'(ov0), 32'(ov));
      chk({nm, ".ov1"}, idx, 32'(ov1), 32'(ov));
      chk({nm, ".q0"},  idx, 32'(q0),  32'(w));
      chk({nm, ".q1"},  idx, 32'(q1),  32'(s));
      chk({nm, ".sf0"}, idx, 32'(sf0), 32'd0);
      chk({nm, ".sf1"}, idx, 32'(sf1), 32'(sf));
   endtask

   task automatic chk_b(input string nm, input int idx, input logic ov, input logic [15:0] q);
      chk({nm, ".ov2"}, idx, 32'(ov2), 32'(ov));
      chk({nm, ".q2"},  idx, 32'(q2),  32'(q));
      chk({nm, ".sf2"}, idx, 32'(sf2), 32'd0);
   endtask

   initial begin
      //           clr   vld   d      ov    w      s      sf
      va[0]  = '{1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 8'h00, 1'b0};
      va[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h10, 8'h10, 1'b0};
      va[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h10, 8'h10, 1'b0};
      va[3]  = '{1'b0, 1'b1, 8'h20, 1'b0, 8'h10, 8'h10, 1'b0};
      va[4]  = '{1'b0, 1'b1, 8'h05, 1'b1, 8'h40, 8'h40, 1'b0};
      va[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h75, 8'h75, 1'b0};
      va[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h75, 8'h75, 1'b0};
      va[7]  = '{1'b0, 1'b1, 8'hC0, 1'b0, 8'h75, 8'h75, 1'b0};
      va[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h6A, 8'hFF, 1'b1};
      va[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h6A, 8'hFF, 1'b1};
      va[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h5F, 8'hFF, 1'b1};
      va[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
      va[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
      va[13] = '{1'b0, 1'b1, 8'h09, 1'b0, 8'h00, 8'h00, 1'b0};
      va[14] = '{1'b1, 1'b1, 8'h07, 1'b0, 8'h00, 8'h00, 1'b0};
      va[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h07, 8'h07, 1'b0};
      va[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h07, 8'h07, 1'b0};
      va[17] = '{1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0};
      va[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b0};
      va[19] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'hFF, 8'hFF, 1'b0};
      va[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hFE, 8'hFF, 1'b1};

      //           clr   vld   d         ov    q
      vb[0]  = '{1'b0, 1'b1, 16'h0503, 1'b0, 16'h0000};
      vb[1]  = '{1'b0, 1'b1, 16'h0503, 1'b0, 16'h0000};
      vb[2]  = '{1'b0, 1'b1, 16'h0503, 1'b1, 16'h0503};
      vb[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0F09};
      vb[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1E12};
      vb[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h1E12};
      vb[6]  = '{1'b0, 1'b1, 16'h0101, 1'b0, 16'h1E12};
      vb[7]  = '{1'b0, 1'b1, 16'h0101, 1'b0, 16'h1E12};
      vb[8]  = '{1'b1, 1'b1, 16'h0707, 1'b0, 16'h0000};
      vb[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
      vb[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0707};
      vb[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0707};

      rst = 1'b1;
      clr_a = 1'b0; vld_a = 1'b0; d_a = '0;
      clr_b = 1'b0; vld_b = 1'b0; d_b = '0;
      repeat (2) step();
      chk_a("rst", 0, 1'b0, 8'h00, 8'h00, 1'b0);
      chk_b("rst", 0, 1'b0, 16'h0000);
      rst = 1'b0;

      // Basic latency, back-to-back samples, saturation boundary, clear.
      for (int i = 0; i < 21; i++) begin
         send_a(va[i].clr, va[i].vld, va[i].d);
         chk_a("tabA", i, va[i].ov, va[i].w, va[i].s, va[i].sf);
      end

      // Fold carry: while acc1 = 255*k (k<=256) the fold is always 0xFF.
      // 19 x 0xFF then 0x03 gives acc1 = 0x12F0, fold = 0xF0+0x12 -> 0x02.
      send_a(1'b1, 1'b0, 8'h00);
      chk_a("fc.clr", 0, 1'b0, 8'h00, 8'h00, 1'b0);
      for (int k = 1; k <= 19; k++) begin
         send_a(1'b0, 1'b1, 8'hFF);
         if (k >= 2) chk("fc.ramp", k, 32'(q0), 32'((256 - (k - 1)) % 256));
      end
      send_a(1'b0, 1'b1, 8'h03);
      chk_a("fc.t19", 0, 1'b1, 8'hED, 8'hFF, 1'b1);
      send_a(1'b0, 1'b1, 8'h00);
      chk_a("fc.t20", 0, 1'b1, 8'hEF, 8'hFF, 1'b1);
      send_a(1'b0, 1'b0, 8'h00);
      chk_a("fc.t21", 0, 1'b1, 8'hF1, 8'hFF, 1'b1);
      send_a(1'b0, 1'b0, 8'h00);
      chk_a("fc.idle", 0, 1'b0, 8'hF1, 8'hFF, 1'b1);

      // acc1 wrap: 257 x 0xFF reaches 0xFFFF (fold 0xFE), then +0x01 -> 0x0000.
      send_a(1'b1, 1'b0, 8'h00);
      for (int k = 1; k <= 257; k++) send_a(1'b0, 1'b1, 8'hFF);
      chk_a("wr.t256", 0, 1'b1, 8'h00, 8'hFF, 1'b1);
      send_a(1'b0, 1'b1, 8'h01);
      chk_a("wr.t257", 0, 1'b1, 8'hFE, 8'hFF, 1'b1);
      send_a(1'b0, 1'b1, 8'h05);
      chk_a("wr.t258", 0, 1'b1, 8'hFE, 8'hFF, 1'b1);
      send_a(1'b0, 1'b0, 8'h00);
      chk_a("wr.t259", 0, 1'b1, 8'h03, 8'hFF, 1'b1);

      // Async reset mid-stream with a token in flight; sticky flag must drop.
      send_a(1'b0, 1'b1, 8'h11);
      chk_a("ra.s1", 0, 1'b0, 8'h03, 8'hFF, 1'b1);
      send_a(1'b0, 1'b1, 8'h22);
      chk_a("ra.s2", 0, 1'b1, 8'h19, 8'hFF, 1'b1);
      #2 rst = 1'b1;
      #1 chk_a("ra.async", 0, 1'b0, 8'h00, 8'h00, 1'b0);
      vld_a = 1'b0; d_a = '0;
      step();
      chk_a("ra.hold", 0, 1'b0, 8'h00, 8'h00, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_a("ra.after", i, 1'b0, 8'h00, 8'h00, 1'b0);
      end

      // Two channels with the fold register: extra cycle of latency.
      for (int i = 0; i < 12; i++) begin
         send_b(vb[i].clr, vb[i].vld, vb[i].d);
         chk_b("tabB", i, vb[i].ov, vb[i].q);
      end

      send_b(1'b0, 1'b1, 16'h0101);
      chk_b("rb.s1", 0, 1'b0, 16'h0707);
      send_b(1'b0, 1'b1, 16'h0101);
      chk_b("rb.s2", 0, 1'b0, 16'h0707);
      #2 rst = 1'b1;
      #1 chk_b("rb.async", 0, 1'b0, 16'h0000);
      vld_b = 1'b0; d_b = '0;
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_b("rb.after", i, 1'b0, 16'h0000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
